key_event_arbiter: RTL and testbench

//  Sequences debounce and press classification for NUM_KEYS raw active-low keys.

---
 rtl/key_event_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Debounce, short/long/repeat classification and RR event arbitration for raw keys.
// Optional auto-repeat in LONG is enabled by defining KEY_REPEAT_EN.
`timescale 1ns/1ps
module key_event_arbiter #(
  parameter int NUM_KEYS       = 3,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_drop
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE, PDB, HELD, LONG, RDB
  } st_t;

  logic [NUM_KEYS-1:0] sync1, sync2, s;
  logic [TW-1:0]       tcnt;
  logic                tick;

  st_t           st_q   [NUM_KEYS];
  st_t           st_d   [NUM_KEYS];
  logic [CW-1:0] cnt_q  [NUM_KEYS];
  logic [CW-1:0] cnt_d  [NUM_KEYS];
  logic [HW-1:0] hold_q [NUM_KEYS];
  logic [HW-1:0] hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q, long_d;
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_q [NUM_KEYS];
  logic [RW-1:0] rep_d [NUM_KEYS];
`endif

  logic [NUM_KEYS-1:0] post, clr, drop_v, pend_q;
  logic [1:0]          post_type [NUM_KEYS];
  logic [1:0]          ptype_q   [NUM_KEYS];
  logic [KW-1:0]       ptr_q, gnt_idx;
  logic [1:0]          gnt_type;
  logic                gnt_any, load;

  assign s = ~sync2;
  assign tick = (tcnt == TW'(TICK_DIV - 1));

  // Two-flop synchronisers and the shared free-running tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      tcnt  <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      tcnt  <= tick ? '0 : tcnt + 1'b1;
    end
  end

  // Per-key FSM state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        st_q[k]   <= IDLE;
        cnt_q[k]  <= '0;
        hold_q[k] <= '0;
`ifdef KEY_REPEAT_EN
        rep_q[k]  <= '0;
`endif
      end
      long_q <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        st_q[k]   <= st_d[k];
        cnt_q[k]  <= cnt_d[k];
        hold_q[k] <= hold_d[k];
`ifdef KEY_REPEAT_EN
        rep_q[k]  <= rep_d[k];
`endif
      end
      long_q <= long_d;
    end
  end

  // Per-key next state; counters only move on tick
  always_comb begin
    long_d = long_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      st_d[k]   = st_q[k];
      cnt_d[k]  = cnt_q[k];
      hold_d[k] = hold_q[k];
`ifdef KEY_REPEAT_EN
      rep_d[k]  = rep_q[k];
`endif
      unique case (st_q[k])
        IDLE: begin
          if (s[k]) begin
            st_d[k]  = PDB;
            cnt_d[k] = '0;
          end
        end
        PDB: begin
          if (!s[k]) begin
            st_d[k] = IDLE;
          end else if (tick) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
            if (cnt_q[k] + 1'b1 == CW'(DEBOUNCE_TICKS)) begin
              st_d[k]   = HELD;
              hold_d[k] = '0;
              long_d[k] = 1'b0;
            end
          end
        end
        HELD: begin
          if (!s[k]) begin
            st_d[k]  = RDB;
            cnt_d[k] = '0;
          end else if (tick) begin
            hold_d[k] = hold_q[k] + 1'b1;
            if (hold_q[k] + 1'b1 == HW'(LONG_TICKS)) begin
              st_d[k]   = LONG;
              long_d[k] = 1'b1;
`ifdef KEY_REPEAT_EN
              rep_d[k]  = '0;
`endif
            end
          end
        end
        LONG: begin
          if (!s[k]) begin
            st_d[k]  = RDB;
            cnt_d[k] = '0;
          end else if (tick) begin
            if (hold_q[k] != HW'(LONG_TICKS))
              hold_d[k] = hold_q[k] + 1'b1;
`ifdef KEY_REPEAT_EN
            if (rep_q[k] + 1'b1 == RW'(REPEAT_TICKS))
              rep_d[k] = '0;
            else
              rep_d[k] = rep_q[k] + 1'b1;
`endif
          end
        end
        RDB: begin
          if (s[k]) begin
            st_d[k] = long_q[k] ? LONG : HELD;
          end else if (tick) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
            if (cnt_q[k] + 1'b1 == CW'(DEBOUNCE_TICKS))
              st_d[k] = IDLE;
          end
        end
        default: st_d[k] = IDLE;
      endcase
    end
  end

  // Per-key outputs: debounced level and event posts
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      post[k]      = 1'b0;
      post_type[k] = 2'b00;
      key_state[k] = (st_q[k] == HELD) || (st_q[k] == LONG) ||
                     (st_q[k] == RDB);
      if (tick) begin
        if (st_q[k] == HELD && s[k] &&
            hold_q[k] + 1'b1 == HW'(LONG_TICKS)) begin
          post[k]      = 1'b1;
          post_type[k] = 2'b01;
        end
`ifdef KEY_REPEAT_EN
        if (st_q[k] == LONG && s[k] &&
            rep_q[k] + 1'b1 == RW'(REPEAT_TICKS)) begin
          post[k]      = 1'b1;
          post_type[k] = 2'b10;
        end
`endif
        if (st_q[k] == RDB && !s[k] && !long_q[k] &&
            cnt_q[k] + 1'b1 == CW'(DEBOUNCE_TICKS)) begin
          post[k]      = 1'b1;
          post_type[k] = 2'b00;
        end
      end
    end
  end

  assign load = !evt_valid || evt_ready;

  // Round-robin pick: first pending slot at or after the pointer
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_type = 2'b00;
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (!gnt_any && pend_q[j] && KW'(j) >= ptr_q) begin
        gnt_any  = 1'b1;
        gnt_idx  = KW'(j);
        gnt_type = ptype_q[j];
      end
    end
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (!gnt_any && pend_q[j]) begin
        gnt_any  = 1'b1;
        gnt_idx  = KW'(j);
        gnt_type = ptype_q[j];
      end
    end
    for (int j = 0; j < NUM_KEYS; j++) begin
      clr[j]    = load && gnt_any && (gnt_idx == KW'(j));
      drop_v[j] = post[j] && pend_q[j] && !clr[j];
    end
  end

  // Pending slots; a grant frees the slot in the same cycle a post may refill it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++)
        ptype_q[k] <= 2'b00;
      evt_drop <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (post[k]) begin
          if (!pend_q[k] || clr[k]) begin
            pend_q[k]  <= 1'b1;
            ptype_q[k] <= post_type[k];
          end
        end else if (clr[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
      evt_drop <= |drop_v;
    end
  end

  // Output event register, reloaded when empty or on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= 2'b00;
      ptr_q     <= '0;
    end else if (load) begin
      evt_valid <= gnt_any;
      if (gnt_any) begin
        evt_key  <= gnt_idx;
        evt_type <= gnt_type;
        ptr_q    <= (gnt_idx == KW'(NUM_KEYS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: debounce, classification, RR order,
// backpressure/drop and mid-press reset.
`timescale 1ns/1ps
module tb_key_event_arbiter;

  localparam int NK = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_state;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;
  logic          evt_drop;

  int checks = 0;
  int errors = 0;
  int drops = 0;
  int cyc = 0;
  bit ks0_seen = 0;
  bit unstable = 0;
  bit hv = 0;
  logic [3:0] hkt = '0;

  typedef struct {
    int k;
    int t;
    int c;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;

  key_event_arbiter #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(3),
    .LONG_TICKS(10), .REPEAT_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_state(key_state), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .evt_drop(evt_drop)
  );

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    if (rst_n && evt_valid && evt_ready) begin
      e.k = int'(evt_key);
      e.t = int'(evt_type);
      e.c = cyc;
      evq.push_back(e);
    end
    if (evt_drop) drops++;
    if (key_state[0]) ks0_seen = 1;
    if (rst_n && evt_valid && !evt_ready) begin
      if (hv && ({evt_key, evt_type} != hkt)) unstable = 1;
      hv = 1;
      hkt = {evt_key, evt_type};
    end else begin
      hv = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    clks(n * TD);
  endtask

  task automatic tap(input logic [NK-1:0] m, input int lo, input int hi);
    key_n = ~m;
    ticks(lo);
    key_n = '1;
    ticks(hi);
  endtask

  task automatic chk_ev(input string tag, input int i,
                        input int k, input int t);
    if (evq.size() > i) begin
      chk({tag, "_key"}, evq[i].k, k);
      chk({tag, "_type"}, evq[i].t, t);
    end else begin
      chk({tag, "_missing"}, evq.size(), i + 1);
    end
  endtask

  initial begin
    // reset state
    clks(3);
    chk("rst_ks", key_state, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_key", evt_key, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_drop", evt_drop, 0);
    rst_n = 1'b1;
    clks(5);

    // bounce on key0: never accepted
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = 1'b0;
      ticks(2);
      key_n[0] = 1'b1;
      ticks(1);
    end
    ticks(10);
    chk("bounce_ks_seen", ks0_seen, 0);
    chk("bounce_events", evq.size(), 0);
    chk("bounce_drops", drops, 0);

    // short press on key1 with latency check
    evt_ready = 1'b0;
    key_n[1] = 1'b0;
    clks(8);
    chk("short_ks_early", key_state[1], 0);
    clks(8);
    chk("short_ks_held", key_state[1], 1);
    clks(16);
    key_n[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!key_state[1]) break;
    end
    chk("short_ks_fall", key_state[1], 0);
    chk("short_valid_n1", evt_valid, 0);
    @(negedge clk);
    chk("short_valid_n2", evt_valid, 1);
    chk("short_key", evt_key, 1);
    chk("short_type", evt_type, 0);
    evt_ready = 1'b1;
    clks(4);
    chk("short_count", evq.size(), 1);
    chk_ev("short_ev", 0, 1, 0);
    chk("short_idle", evt_valid, 0);
    evq.delete();

    // long press on key0
    tap(3'b001, 24, 10);
`ifdef KEY_REPEAT_EN
    chk("long_count", evq.size(), 3);
    chk_ev("long_ev", 0, 0, 1);
    chk_ev("rep1_ev", 1, 0, 2);
    chk_ev("rep2_ev", 2, 0, 2);
`else
    chk("long_count", evq.size(), 1);
    chk_ev("long_ev", 0, 0, 1);
`endif
    evq.delete();

    // key2 short press moves pointer back to 0
    tap(3'b100, 6, 6);
    chk("k2_count", evq.size(), 1);
    chk_ev("k2_ev", 0, 2, 0);
    evq.delete();

    // simultaneous release, pointer 0 -> order 0,1,2
    tap(3'b111, 6, 6);
    chk("arb_count", evq.size(), 3);
    chk_ev("arb_a", 0, 0, 0);
    chk_ev("arb_b", 1, 1, 0);
    chk_ev("arb_c", 2, 2, 0);
    if (evq.size() == 3) begin
      chk("arb_b2b1", evq[1].c - evq[0].c, 1);
      chk("arb_b2b2", evq[2].c - evq[1].c, 1);
    end
    evq.delete();

    // key1 alone leaves pointer at 2 -> order 2,0,1
    tap(3'b010, 6, 6);
    chk("k1_count", evq.size(), 1);
    evq.delete();
    tap(3'b111, 6, 6);
    chk("rr_count", evq.size(), 3);
    chk_ev("rr_a", 0, 2, 0);
    chk_ev("rr_b", 1, 0, 0);
    chk_ev("rr_c", 2, 1, 0);
    evq.delete();

    // backpressure: three presses on key2, third is dropped
    evt_ready = 1'b0;
    tap(3'b100, 6, 6);
    tap(3'b100, 6, 6);
    chk("bp_drops_pre", drops, 0);
    tap(3'b100, 6, 6);
    chk("bp_drops", drops, 1);
    chk("bp_valid", evt_valid, 1);
    chk("bp_key", evt_key, 2);
    chk("bp_type", evt_type, 0);
    chk("bp_stable", unstable, 0);
    evt_ready = 1'b1;
    clks(10);
    chk("bp_count", evq.size(), 2);
    chk_ev("bp_a", 0, 2, 0);
    chk_ev("bp_b", 1, 2, 0);
    chk("bp_idle", evt_valid, 0);
    evq.delete();

    // reset while key1 held
    key_n[1] = 1'b0;
    ticks(8);
    chk("rst_mid_ks_pre", key_state[1], 1);
    rst_n = 1'b0;
    clks(2);
    chk("rst_mid_ks", key_state, 0);
    chk("rst_mid_valid", evt_valid, 0);
    chk("rst_mid_drop", evt_drop, 0);
    chk("rst_mid_key", evt_key, 0);
    rst_n = 1'b1;
    clks(1);
    chk("rst_rel_ks", key_state[1], 0);
    ticks(6);
    chk("rst_redeb_ks", key_state[1], 1);
    ticks(2);
    key_n[1] = 1'b1;
    ticks(6);
    chk("rst_count", evq.size(), 1);
    chk_ev("rst_ev", 0, 1, 0);
    chk("total_drops", drops, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
